// File: rtl/hilo_muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit owning the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle; sign fix-up and HI/LO write in a final cycle.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wr_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] rs_raw_q, rs_raw_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_signed;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_diff;
    logic [63:0] prod_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  if (cnt_q == 6'd31) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // busy/done are registered so they line up with the state they describe.
    always_comb begin
        busy_d = (state_d != StIdle);
        done_d = (state_q == StFix);
    end

    always_comb begin
        is_signed = ~op[0];
        rs_mag    = (is_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
        rt_mag    = (is_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
        rem_shift = acc_q[63:31];
        rem_ge    = (rem_shift >= {1'b0, opnd_q});
        // When rem_ge holds the difference is below the divisor, so 32 bits suffice.
        rem_diff  = rem_shift[31:0] - opnd_q;
        prod_fix  = neg_res_q ? (64'd0 - acc_q) : acc_q;
    end

    always_comb begin
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        rs_raw_d  = rs_raw_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_res_d = is_signed & (rs_data[31] ^ rt_data[31]);
                    neg_rem_d = is_signed & rs_data[31];
                    div0_d    = (rt_data == 32'd0);
                    cnt_d     = 6'd0;
                    rs_raw_d  = rs_data;
                    // Multiply: multiplicand held, multiplier shifts out of acc LSB.
                    // Divide: divisor held, dividend shifts out of acc bit 31.
                    opnd_d    = op[1] ? rt_mag : rs_mag;
                    acc_d     = {32'd0, (op[1] ? rs_mag : rt_mag)};
                end else begin
                    if (mthi) hi_d = wr_data;
                    if (mtlo) lo_d = wr_data;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + 6'd1;
                if (is_div_q) begin
                    acc_d = {(rem_ge ? rem_diff : rem_shift[31:0]), acc_q[30:0], rem_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
            end
            StFix: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (div0_q) begin
                    hi_d = rs_raw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                    lo_d = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            cnt_q     <= 6'd0;
            opnd_q    <= 32'd0;
            rs_raw_q  <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            rs_raw_q  <= rs_raw_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: arithmetic results, busy/done timing, MT writes,
// ignored requests while busy, mid-operation reset and back-to-back issue.
module tb_hilo_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wr_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_chk;
    int n_fail;

    hilo_muldiv_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wr_data (wr_data),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge where done is seen (or after the budget).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int bcyc, output bit seen_done);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        rs_data = 32'hDEAD_BEEF;
        rt_data = 32'h1234_5678;
        bcyc    = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (busy) bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_chk++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_multu_max();
        int bc; bit sd;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, sd);
        n_chk++; if (sd !== 1'b1) begin n_fail++; $display("FAIL multu_done_seen: got %b want 1", sd); end
        n_chk++; if (bc != 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
        n_chk++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_chk++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(negedge clk);
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult_signed();
        int bc; bit sd;
        run_op(2'b00, 32'hFFFF_FFF9, 32'h0000_0006, bc, sd);
        n_chk++; if (sd !== 1'b1) begin n_fail++; $display("FAIL mult_done_seen: got %b want 1", sd); end
        n_chk++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_chk++; if (lo !== 32'hFFFF_FFD6) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffd6", lo); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int bc; bit sd;
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, bc, sd);
        n_chk++; if (bc != 33) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 33", bc); end
        n_chk++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_chk++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        @(negedge clk);
        run_op(2'b11, 32'd100, 32'd7, bc, sd);
        n_chk++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        n_chk++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want 00000002", hi); end
        @(negedge clk);
    endtask

    task automatic test_div_corner();
        int bc; bit sd;
        run_op(2'b11, 32'd5, 32'd0, bc, sd);
        n_chk++; if (bc != 33) begin n_fail++; $display("FAIL div0_busy_cycles: got %0d want 33", bc); end
        n_chk++; if (hi !== 32'd5) begin n_fail++; $display("FAIL div0_hi: got %h want 00000005", hi); end
        n_chk++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        @(negedge clk);
        // Signed divide by zero: HI keeps the raw dividend, no sign fix-up.
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, bc, sd);
        n_chk++; if (hi !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL div0s_hi: got %h want fffffff9", hi); end
        n_chk++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0s_lo: got %h want ffffffff", lo); end
        @(negedge clk);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bc, sd);
        n_chk++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
        n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL divovf_hi: got %h want 0", hi); end
        @(negedge clk);
    endtask

    task automatic test_mt_writes();
        bit sd;
        int bc;
        mthi = 1'b1; wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 1'b0;
        n_chk++; if (hi !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mthi_idle: got %h want a5a5a5a5", hi); end
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h1357_9BDF;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        n_chk++; if (hi !== 32'h1357_9BDF) begin n_fail++; $display("FAIL mthilo_hi: got %h want 13579bdf", hi); end
        n_chk++; if (lo !== 32'h1357_9BDF) begin n_fail++; $display("FAIL mthilo_lo: got %h want 13579bdf", lo); end
        mthi = 1'b1; wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 1'b0;
        // MULTU 3x4 with an MTHI and a second start arriving mid-operation.
        start = 1'b1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        mthi = 1'b1; wr_data = 32'h0BAD_0BAD;
        start = 1'b1; op = 2'b00; rs_data = 32'd9; rt_data = 32'd9;
        @(negedge clk);
        mthi = 1'b0; start = 1'b0;
        n_chk++; if (hi !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mthi_busy_hold: got %h want a5a5a5a5", hi); end
        n_chk++; if (lo !== 32'h1357_9BDF) begin n_fail++; $display("FAIL lo_calc_hold: got %h want 13579bdf", lo); end
        sd = 1'b0; bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin sd = 1'b1; break; end
            @(negedge clk);
        end
        n_chk++; if (sd !== 1'b1) begin n_fail++; $display("FAIL mt_op_done_seen: got %b want 1", sd); end
        n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL mt_op_hi: got %h want 0", hi); end
        n_chk++; if (lo !== 32'd12) begin n_fail++; $display("FAIL mt_op_lo: got %h want 0000000c", lo); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        n_chk++; if (bc != 0) begin n_fail++; $display("FAIL no_queued_start: got %0d busy cycles want 0", bc); end
    endtask

    task automatic test_start_wins();
        int bc; bit sd;
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h7777_7777;
        start = 1'b1; op = 2'b01; rs_data = 32'd2; rt_data = 32'd3;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
        n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL start_wins_hi: got %h want 0", hi); end
        n_chk++; if (lo !== 32'd12) begin n_fail++; $display("FAIL start_wins_lo: got %h want 0000000c", lo); end
        sd = 1'b0; bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin sd = 1'b1; break; end
            @(negedge clk);
        end
        n_chk++; if (lo !== 32'd6) begin n_fail++; $display("FAIL start_wins_result: got %h want 00000006", lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dcnt;
        start = 1'b1; op = 2'b11; rs_data = 32'd1000; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hi: got %h want 0", hi); end
        n_chk++; if (lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid_lo: got %h want 0", lo); end
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        n_chk++; if (dcnt != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", dcnt); end
    endtask

    task automatic test_back_to_back();
        int bc; bit sd;
        run_op(2'b01, 32'd3, 32'd5, bc, sd);
        n_chk++; if (lo !== 32'd15) begin n_fail++; $display("FAIL post_rst_multu_lo: got %h want 0000000f", lo); end
        n_chk++; if (bc != 33) begin n_fail++; $display("FAIL post_rst_busy_cycles: got %0d want 33", bc); end
        // Issue immediately so the start is sampled at the first IDLE edge.
        run_op(2'b11, 32'd50, 32'd8, bc, sd);
        n_chk++; if (bc != 33) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 33", bc); end
        n_chk++; if (lo !== 32'd6) begin n_fail++; $display("FAIL b2b_lo: got %h want 00000006", lo); end
        n_chk++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_hi: got %h want 00000002", hi); end
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div();
        test_div_corner();
        test_mt_writes();
        test_start_wins();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
